// File: rtl/prog_mem_loader.sv
// prog_mem_loader: writer side of the instruction memory read by the fetch stage.
// Bytes from the UART receiver are assembled MSB-first into 32-bit words. Each
// word is written to the next sequential word address, starting at 0. Loading
// stops once the HALT word has been written (o_load_done). It also stops if the
// memory fills up before HALT arrives (o_error). Both flags are sticky until reset.
// Optional feature macro: LOADER_CHECKSUM_EN adds o_checksum, the running XOR of
// all accepted bytes. The value freezes once loading stops.
module prog_mem_loader #(
  parameter int          ADDR_BITS = 11,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_mem_wr_en,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [31:0]          o_mem_data,
  output logic                 o_load_done,
  output logic                 o_error
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]           o_checksum
`endif
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_WRITE   = 2'd1,
    S_DONE    = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [1:0]             r_byte_cnt;
  // Only the three most recent bytes need to be held. The oldest byte leaves
  // the shift register at the same edge the completed word is captured.
  logic [23:0]            r_shift_reg;
  logic [31:0]            r_word_reg;
  logic [ADDR_BITS-1:0]   r_wr_addr;
  logic [ADDR_BITS-1:0]   r_mem_addr;
  logic                   r_mem_wr_en;
  logic                   w_accept;
  logic                   w_word_complete;
  logic [31:0]            w_assembled;

  // Byte acceptance and word assembly. Bytes are also taken during WRITE, so a
  // host streaming back-to-back never loses the first byte of the next word.
  always_comb begin
    w_accept        = i_rx_valid && ((r_state == S_COLLECT) || (r_state == S_WRITE));
    w_assembled     = {r_shift_reg, i_rx_data};
    w_word_complete = w_accept && (r_byte_cnt == 2'd3);
  end

  // Next-state logic. The HALT check comes before the overflow check, so a
  // HALT word at the last address ends in DONE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_state_next = r_state;
    unique case (r_state)
      S_COLLECT: if (w_word_complete) w_state_next = S_WRITE;
      S_WRITE: begin
        if (r_word_reg == HALT_WORD)      w_state_next = S_DONE;
        else if (r_wr_addr == LAST_ADDR)  w_state_next = S_ERROR;
        else                              w_state_next = S_COLLECT;
      end
      S_DONE:    w_state_next = S_DONE;
      S_ERROR:   w_state_next = S_ERROR;
      default:   w_state_next = S_COLLECT;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!i_reset) r_state <= S_COLLECT;
    else          r_state <= w_state_next;
  end

  // Datapath: byte shifting, word capture, write strobe and address tracking.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_byte_cnt  <= 2'd0;
      r_shift_reg <= '0;
      r_word_reg  <= '0;
      r_wr_addr   <= '0;
      r_mem_addr  <= '0;
      r_mem_wr_en <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift_reg <= w_assembled[23:0];
        r_byte_cnt  <= r_byte_cnt + 2'd1;
      end
      // The completed word and its address are captured together. The memory
      // port then holds the last written address and data between writes.
      if (w_word_complete) begin
        r_word_reg <= w_assembled;
        r_mem_addr <= r_wr_addr;
      end
      // Write is high only during the single WRITE cycle.
      r_mem_wr_en <= (w_state_next == S_WRITE);
      if ((r_state == S_WRITE) && (w_state_next == S_COLLECT))
        r_wr_addr <= r_wr_addr + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  // Running XOR of accepted bytes. No bytes are accepted in DONE or ERROR,
  // so the value freezes there.
  always_ff @(posedge i_clock) begin
    if (!i_reset)      r_checksum <= 8'h00;
    else if (w_accept) r_checksum <= r_checksum ^ i_rx_data;
  end

  assign o_checksum = r_checksum;
`endif

  assign o_mem_wr_en = r_mem_wr_en;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_word_reg;
  assign o_load_done = (r_state == S_DONE);
  assign o_error     = (r_state == S_ERROR);

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader. The DUT uses a 4-word memory, so
// overflow is easy to reach. A word-level reference model predicts every
// output after each rising edge. A compare process checks the DUT against it
// on every falling edge. Directed sequences add literal expectations, and
// randomized byte streams with gaps, HALT words and mid-word resets follow.
module tb_prog_mem_loader;

  localparam int          AB       = 2;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
  localparam int          MAX_ADDR = (1 << AB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          wr_en;
  logic [AB-1:0] addr;
  logic [31:0]   data;
  logic          done;
  logic          err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  int errors = 0;
  int checks = 0;

  prog_mem_loader #(.ADDR_BITS(AB), .HALT_WORD(HALT)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_mem_wr_en(wr_en),
    .o_mem_addr (addr),
    .o_mem_data (data),
    .o_load_done(done),
    .o_error    (err)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_checksum (csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: count bytes and words and track the write that is due.
  bit          m_live = 0;
  int          m_cnt, m_next_addr, m_out_addr;
  logic [31:0] m_cur, m_word;
  bit          m_wr, m_done, m_err;
  logic [7:0]  m_xor;

  // Advance the model by one clock using the inputs the DUT samples at this edge.
  always @(posedge clk) begin
    bit stopped, was_wr;
    if (!rst) begin
      m_live = 1; m_cnt = 0; m_cur = 0; m_word = 0; m_next_addr = 0;
      m_out_addr = 0; m_wr = 0; m_done = 0; m_err = 0; m_xor = 0;
    end else if (m_live) begin
      stopped = m_done || m_err;
      was_wr  = m_wr;
      m_wr    = 0;
      if (was_wr) begin
        if (m_word == HALT)               m_done = 1;
        else if (m_out_addr == MAX_ADDR)  m_err  = 1;
        else                              m_next_addr = m_out_addr + 1;
      end
      if (rx_valid && !stopped) begin
        m_cur = {m_cur[23:0], rx_data};
        m_xor = m_xor ^ rx_data;
        m_cnt++;
        if (m_cnt == 4) begin
          m_cnt = 0; m_word = m_cur; m_out_addr = m_next_addr; m_wr = 1;
        end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (m_live) begin
      check("wr_en", {31'd0, wr_en}, {31'd0, m_wr});
      check("addr",  {{(32-AB){1'b0}}, addr}, m_out_addr);
      check("data",  data, m_word);
      check("done",  {31'd0, done}, {31'd0, m_done});
      check("error", {31'd0, err}, {31'd0, m_err});
`ifdef LOADER_CHECKSUM_EN
      check("checksum", {24'd0, csum}, {24'd0, m_xor});
`endif
    end
  end

  // Drive one clock's worth of inputs. The values are set on the falling edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit r);
    @(negedge clk);
    rst      = r;
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 1);
  endtask

  task automatic do_reset();
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) cyc(1, w[i*8 +: 8], 1);
  endtask

  initial begin
    logic [31:0] w;
    // The design has no power-on values, so reset comes first.
    do_reset();
    check("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check("reset_data",  data, 32'd0);
    check("reset_done",  {31'd0, done}, 32'd0);

    // A single word is written one cycle after its fourth byte.
    send_word(32'h2001_0005);
    idle(1);
    check("t1_wr_en", {31'd0, wr_en}, 32'd1);
    check("t1_addr",  {30'd0, addr}, 32'd0);
    check("t1_data",  data, 32'h2001_0005);
    check("t1_done",  {31'd0, done}, 32'd0);
    idle(1);
    check("t1_wr_low", {31'd0, wr_en}, 32'd0);

    // Two words back-to-back, the second is HALT and streams through the WRITE cycle.
    do_reset();
    send_word(32'h8C02_0004);
    send_word(HALT);
    idle(1);
    check("t2_wr_en", {31'd0, wr_en}, 32'd1);
    check("t2_addr",  {30'd0, addr}, 32'd1);
    check("t2_data",  data, HALT);
    idle(1);
    check("t2_done",  {31'd0, done}, 32'd1);
    cyc(1, 8'hAA, 1);
    idle(3);
    check("t2_no_wr", {31'd0, wr_en}, 32'd0);

    // A reset while in DONE clears everything and loading restarts at address 0.
    do_reset();
    check("t5_done_clr", {31'd0, done}, 32'd0);
    check("t5_data_clr", data, 32'd0);
    send_word(32'hCAFE_0001);
    idle(1);
    check("t5_addr", {30'd0, addr}, 32'd0);
    check("t5_wr",   {31'd0, wr_en}, 32'd1);

    // Five non-HALT words into a 4-word memory overflow after the write at address 3.
    do_reset();
    for (int k = 0; k < 5; k++) send_word(32'h1000_0000 + k);
    idle(2);
    check("t3_error", {31'd0, err}, 32'd1);
    check("t3_addr",  {30'd0, addr}, 32'd3);
    check("t3_data",  data, 32'h1000_0003);

    // A HALT word at the last address ends in DONE, not ERROR.
    do_reset();
    for (int k = 0; k < 3; k++) send_word(32'h2000_0000 + k);
    send_word(HALT);
    idle(2);
    check("t3b_done",  {31'd0, done}, 32'd1);
    check("t3b_error", {31'd0, err}, 32'd0);

    // A reset in mid-word discards the partial bytes.
    do_reset();
    cyc(1, 8'hDE, 1);
    cyc(1, 8'hAD, 1);
    cyc(0, 8'h00, 0);
    send_word(32'h1234_5678);
    idle(1);
    check("t4_data", data, 32'h1234_5678);
    check("t4_addr", {30'd0, addr}, 32'd0);
    check("t4_wr",   {31'd0, wr_en}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // The checksum ignores the HALT bytes because they XOR to zero.
    do_reset();
    send_word(32'h0102_0408);
    send_word(HALT);
    idle(3);
    check("t6_checksum", {24'd0, csum}, 32'h0000_000F);
`endif

    // Randomized streams with gaps, HALT words and occasional mid-word resets.
    for (int rep = 0; rep < 40; rep++) begin
      do_reset();
      for (int n = 0; n < int'($urandom_range(1, 7)); n++) begin
        w = ($urandom_range(0, 4) == 0) ? HALT : $urandom;
        for (int i = 3; i >= 0; i--) begin
          idle(int'($urandom_range(0, 2)));
          cyc(1, w[i*8 +: 8], 1);
          if ($urandom_range(0, 60) == 0) cyc(0, 8'h00, 0);
        end
      end
      idle(3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
